// File: rtl/onplay_sequencer_pkg.sv
// Shared game parameters: ONPLAY_*/GAME_* constants, stage indices and
// sequencer state encodings.
package onplay_sequencer_pkg;

    localparam int unsigned GAME_PHASE_W      = 2;
    localparam int unsigned GAME_PHASE_LAST   = 3;
    localparam int unsigned GAME_PHASE_CNT_W  = 7;
    localparam int unsigned ONPLAY_STAGES     = 4;
    localparam int unsigned ONPLAY_TIMER_W    = 8;

    localparam int unsigned MAX_PHASE_CNT_DEF = 99;
    localparam int unsigned STAGE_TIMEOUT_DEF = 255;

    localparam int unsigned STG_CALC      = 0;
    localparam int unsigned STG_MOVE      = 1;
    localparam int unsigned STG_COLLISION = 2;
    localparam int unsigned STG_CHECK     = 3;

    typedef enum logic [3:0] {
        ST_IDLE            = 4'd0,
        ST_WAIT            = 4'd1,
        ST_START_CALC      = 4'd2,
        ST_RUN_CALC        = 4'd3,
        ST_START_MOVE      = 4'd4,
        ST_RUN_MOVE        = 4'd5,
        ST_START_COLLISION = 4'd6,
        ST_RUN_COLLISION   = 4'd7,
        ST_START_CHECK     = 4'd8,
        ST_RUN_CHECK       = 4'd9
    } state_t;

    function automatic logic is_start(input state_t s);
        return s inside {ST_START_CALC, ST_START_MOVE, ST_START_COLLISION, ST_START_CHECK};
    endfunction

    function automatic logic is_run(input state_t s);
        return s inside {ST_RUN_CALC, ST_RUN_MOVE, ST_RUN_COLLISION, ST_RUN_CHECK};
    endfunction

    // Stage index of a START/RUN state; IDLE/WAIT map to 0 and are always gated by the caller.
    function automatic logic [1:0] stage_idx(input state_t s);
        case (s)
            ST_START_MOVE,      ST_RUN_MOVE:      return 2'(STG_MOVE);
            ST_START_COLLISION, ST_RUN_COLLISION: return 2'(STG_COLLISION);
            ST_START_CHECK,     ST_RUN_CHECK:     return 2'(STG_CHECK);
            default:                              return 2'(STG_CALC);
        endcase
    endfunction

    function automatic logic [ONPLAY_STAGES-1:0] start_onehot(input state_t s);
        logic [ONPLAY_STAGES-1:0] oh;
        oh = '0;
        if (is_start(s)) oh[stage_idx(s)] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/onplay_sequencer_phase_counter.sv
// Difficulty phase tracker: frame count within a phase and a saturating phase index.
module phase_counter
    import onplay_sequencer_pkg::*;
#(
    parameter int unsigned MAX_PHASE_CNT = MAX_PHASE_CNT_DEF
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Inc,
    input  logic                        i_Clear,
    output logic [GAME_PHASE_W-1:0]     o_Phase,
    output logic [GAME_PHASE_CNT_W-1:0] o_PhaseCnt,
    output logic                        o_Wrap
);

    localparam logic [GAME_PHASE_CNT_W-1:0] CNT_MAX   = GAME_PHASE_CNT_W'(MAX_PHASE_CNT);
    localparam logic [GAME_PHASE_W-1:0]     PHASE_TOP = GAME_PHASE_W'(GAME_PHASE_LAST);

    // Clear has priority over a coincident increment.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Phase    <= '0;
            o_PhaseCnt <= '0;
            o_Wrap     <= 1'b0;
        end else begin
            o_Wrap <= 1'b0;
            if (i_Clear) begin
                o_Phase    <= '0;
                o_PhaseCnt <= '0;
            end else if (i_Inc) begin
                if (o_PhaseCnt < CNT_MAX) begin
                    o_PhaseCnt <= o_PhaseCnt + GAME_PHASE_CNT_W'(1);
                end else begin
                    o_PhaseCnt <= '0;
                    o_Wrap     <= 1'b1;
                    if (o_Phase != PHASE_TOP) o_Phase <= o_Phase + GAME_PHASE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/onplay_sequencer.sv
// Per-frame stage sequencer: CALC -> MOVE -> COLLISION -> CHECK on each frame
// tick, with stage watchdog, overrun detection and difficulty phase tracking.
module onplay_sequencer
    import onplay_sequencer_pkg::*;
#(
    parameter int unsigned MAX_PHASE_CNT = MAX_PHASE_CNT_DEF,
    parameter int unsigned STAGE_TIMEOUT = STAGE_TIMEOUT_DEF
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic                        i_Enable,
    input  logic                        i_Clear,
    input  logic                        i_FrameTick,
    input  logic [ONPLAY_STAGES-1:0]    i_StageDone,
    output logic [ONPLAY_STAGES-1:0]    o_StageStart,
    output logic [GAME_PHASE_W-1:0]     o_Phase,
    output logic [GAME_PHASE_CNT_W-1:0] o_PhaseCnt,
    output logic                        o_PhaseAdvance,
    output logic                        o_FireTick,
    output logic                        o_Busy,
    output logic                        o_Overrun,
    output logic                        o_Timeout
);

    localparam logic [ONPLAY_TIMER_W-1:0]   TIMER_LAST = ONPLAY_TIMER_W'(STAGE_TIMEOUT - 1);
    localparam logic [GAME_PHASE_CNT_W-1:0] CNT_MAX    = GAME_PHASE_CNT_W'(MAX_PHASE_CNT);

    state_t                    state, next_state;
    logic [ONPLAY_TIMER_W-1:0] timer, timer_c;
    logic                      fire_pend, fire_pend_c;
    logic                      run_done_c, timeout_hit_c, calc_inc_c, wrap_now_c;
    logic [ONPLAY_STAGES-1:0]  stage_start_c;
    logic                      busy_c, fire_c, overrun_c, timeout_c;

    assign run_done_c    = is_run(state) && i_StageDone[stage_idx(state)];
    assign timeout_hit_c = is_run(state) && !run_done_c && (timer == TIMER_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!i_Enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:            next_state = ST_WAIT;
                ST_WAIT:            if (i_FrameTick) next_state = ST_START_CALC;
                ST_START_CALC:      next_state = ST_RUN_CALC;
                ST_START_MOVE:      next_state = ST_RUN_MOVE;
                ST_START_COLLISION: next_state = ST_RUN_COLLISION;
                ST_START_CHECK:     next_state = ST_RUN_CHECK;
                ST_RUN_CALC:        if (run_done_c) next_state = ST_START_MOVE;
                                    else if (timeout_hit_c) next_state = ST_WAIT;
                ST_RUN_MOVE:        if (run_done_c) next_state = ST_START_COLLISION;
                                    else if (timeout_hit_c) next_state = ST_WAIT;
                ST_RUN_COLLISION:   if (run_done_c) next_state = ST_START_CHECK;
                                    else if (timeout_hit_c) next_state = ST_WAIT;
                ST_RUN_CHECK:       if (run_done_c || timeout_hit_c) next_state = ST_WAIT;
                default:            next_state = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; decoded from next_state so they line up with the state.
    always_comb begin
        calc_inc_c    = i_Enable && (state == ST_RUN_CALC) && run_done_c;
        wrap_now_c    = calc_inc_c && !i_Clear && !(o_PhaseCnt < CNT_MAX);
        stage_start_c = start_onehot(next_state);
        busy_c        = !(next_state inside {ST_IDLE, ST_WAIT});
        fire_c        = (next_state == ST_START_MOVE) && (fire_pend || wrap_now_c) && !i_Clear;

        fire_pend_c = fire_pend;
        if (i_Clear || !i_Enable || state == ST_START_MOVE) fire_pend_c = 1'b0;
        else if (wrap_now_c)                                fire_pend_c = 1'b1;

        overrun_c = o_Overrun || (i_FrameTick && !(state inside {ST_IDLE, ST_WAIT}));
        timeout_c = o_Timeout || (i_Enable && timeout_hit_c);
        if (i_Clear) begin
            overrun_c = 1'b0;
            timeout_c = 1'b0;
        end

        timer_c = timer;
        if (is_start(state))    timer_c = '0;
        else if (is_run(state)) timer_c = timer + ONPLAY_TIMER_W'(1);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_StageStart <= '0;
            o_FireTick   <= 1'b0;
            o_Busy       <= 1'b0;
            o_Overrun    <= 1'b0;
            o_Timeout    <= 1'b0;
            timer        <= '0;
            fire_pend    <= 1'b0;
        end else begin
            o_StageStart <= stage_start_c;
            o_FireTick   <= fire_c;
            o_Busy       <= busy_c;
            o_Overrun    <= overrun_c;
            o_Timeout    <= timeout_c;
            timer        <= timer_c;
            fire_pend    <= fire_pend_c;
        end
    end

    phase_counter #(
        .MAX_PHASE_CNT (MAX_PHASE_CNT)
    ) u_phase_counter (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Inc      (calc_inc_c),
        .i_Clear    (i_Clear),
        .o_Phase    (o_Phase),
        .o_PhaseCnt (o_PhaseCnt),
        .o_Wrap     (o_PhaseAdvance)
    );

endmodule

// File: tb/tb_onplay_sequencer.sv
// Directed bench for onplay_sequencer with a short phase (MAX_PHASE_CNT=2).
module tb_onplay_sequencer;

    localparam int unsigned MAXP = 2;
    localparam int unsigned TOUT = 255;

    logic       clk = 1'b0;
    logic       rst_n, en, clr, tick;
    logic [3:0] done;
    logic [3:0] stage_start;
    logic [1:0] phase;
    logic [6:0] phase_cnt;
    logic       adv, fire, busy, overrun, timeout;

    int vectors     = 0;
    int miscompares = 0;
    int m_cnt       = 0;
    int m_phase     = 0;
    int m_wrap      = 0;

    always #5 clk = ~clk;

    onplay_sequencer #(
        .MAX_PHASE_CNT (MAXP),
        .STAGE_TIMEOUT (TOUT)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst_n),
        .i_Enable       (en),
        .i_Clear        (clr),
        .i_FrameTick    (tick),
        .i_StageDone    (done),
        .o_StageStart   (stage_start),
        .o_Phase        (phase),
        .o_PhaseCnt     (phase_cnt),
        .o_PhaseAdvance (adv),
        .o_FireTick     (fire),
        .o_Busy         (busy),
        .o_Overrun      (overrun),
        .o_Timeout      (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"},   32'(stage_start), 32'd0);
        chk({tag, "_phase"},   32'(phase),       32'd0);
        chk({tag, "_cnt"},     32'(phase_cnt),   32'd0);
        chk({tag, "_adv"},     32'(adv),         32'd0);
        chk({tag, "_fire"},    32'(fire),        32'd0);
        chk({tag, "_busy"},    32'(busy),        32'd0);
        chk({tag, "_overrun"}, 32'(overrun),     32'd0);
        chk({tag, "_timeout"}, 32'(timeout),     32'd0);
    endtask

    task automatic model_calc(input bit cleared);
        if (cleared) begin
            m_cnt = 0; m_phase = 0; m_wrap = 0;
        end else if (m_cnt < int'(MAXP)) begin
            m_cnt++; m_wrap = 0;
        end else begin
            m_cnt = 0; m_wrap = 1;
            if (m_phase < 3) m_phase++;
        end
    endtask

    task automatic check_move_start();
        chk("move_start", 32'(stage_start), 32'd2);
        chk("move_cnt",   32'(phase_cnt),   32'(m_cnt));
        chk("move_phase", 32'(phase),       32'(m_phase));
        chk("move_adv",   32'(adv),         32'(m_wrap));
        chk("move_fire",  32'(fire),        32'(m_wrap));
    endtask

    // Entered at the negedge where START_s is visible; leaves at START_(s+1) or WAIT.
    task automatic run_stage(input int s, input bit tick_at_done, input bit clr_at_done);
        if (s == 1) check_move_start();
        else        chk("stage_start", 32'(stage_start), 32'(1 << s));
        step();
        chk("start_width", 32'(stage_start), 32'd0);
        if (s == 1) begin
            chk("adv_width",  32'(adv),  32'd0);
            chk("fire_width", 32'(fire), 32'd0);
        end
        step();
        done = 4'(1 << s); tick = tick_at_done; clr = clr_at_done;
        step();
        done = 4'd0; tick = 1'b0; clr = 1'b0;
        if (s == 0) model_calc(clr_at_done);
    endtask

    task automatic start_frame();
        chk("pre_frame_busy", 32'(busy), 32'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic run_frame();
        start_frame();
        for (int s = 0; s < 4; s++) run_stage(s, 1'b0, 1'b0);
        chk("frame_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; tick = 1'b0; done = 4'd0;
        step(); step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();
        chk_zero("idle_disabled");

        // Enable -> WAIT; done bits outside RUN states are ignored
        en = 1'b1;
        step();
        chk("wait_busy", 32'(busy), 32'd0);
        done = 4'hF;
        step();
        done = 4'd0;
        chk("done_in_wait_start", 32'(stage_start), 32'd0);
        chk("done_in_wait_busy",  32'(busy),        32'd0);

        // Single frame: pulses 1,2,4,8; back to WAIT with count 1
        run_frame();
        chk("frame1_cnt", 32'(phase_cnt), 32'd1);

        // Frames 2..12: wraps at frames 3,6,9,12; phase saturates at 3
        for (int f = 2; f <= 12; f++) run_frame();
        chk("sat_phase", 32'(phase), 32'd3);
        chk("sat_cnt",   32'(phase_cnt), 32'd0);

        // Withheld MOVE done: watchdog expires after 255 RUN cycles
        start_frame();
        run_stage(0, 1'b0, 1'b0);
        check_move_start();
        repeat (TOUT) step();
        chk("to_before_flag", 32'(timeout), 32'd0);
        chk("to_before_busy", 32'(busy),    32'd1);
        step();
        chk("to_flag",  32'(timeout),     32'd1);
        chk("to_busy",  32'(busy),        32'd0);
        chk("to_start", 32'(stage_start), 32'd0);
        step();
        chk("to_no_collision", 32'(stage_start), 32'd0);
        run_frame();
        chk("to_sticky", 32'(timeout), 32'd1);
        chk("to_next_cnt", 32'(phase_cnt), 32'(m_cnt));

        // Frame tick during RUN_COLLISION is dropped and flagged
        start_frame();
        run_stage(0, 1'b0, 1'b0);
        run_stage(1, 1'b0, 1'b0);
        chk("coll_start", 32'(stage_start), 32'd4);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ovr_flag",  32'(overrun),     32'd1);
        chk("ovr_busy",  32'(busy),        32'd1);
        chk("ovr_start", 32'(stage_start), 32'd0);
        step();
        done = 4'd4;
        step();
        done = 4'd0;
        run_stage(3, 1'b0, 1'b0);
        chk("ovr_end_busy", 32'(busy), 32'd0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        model_calc(1'b1);
        chk("clr_overrun", 32'(overrun),   32'd0);
        chk("clr_timeout", 32'(timeout),   32'd0);
        chk("clr_phase",   32'(phase),     32'd0);
        chk("clr_cnt",     32'(phase_cnt), 32'd0);

        // Clear coinciding with CALC done wins; tick with CHECK done is dropped
        start_frame();
        run_stage(0, 1'b0, 1'b1);
        run_stage(1, 1'b0, 1'b0);
        run_stage(2, 1'b0, 1'b0);
        run_stage(3, 1'b1, 1'b0);
        chk("chkdone_tick_overrun", 32'(overrun), 32'd1);
        chk("chkdone_tick_busy",    32'(busy),    32'd0);
        step();
        chk("chkdone_tick_dropped", 32'(stage_start), 32'd0);

        // Enable drop in RUN_MOVE, then async reset mid-frame
        start_frame();
        run_stage(0, 1'b0, 1'b0);
        check_move_start();
        step();
        en = 1'b0;
        step();
        chk("dis_busy",  32'(busy),        32'd0);
        chk("dis_start", 32'(stage_start), 32'd0);
        chk("dis_cnt",   32'(phase_cnt),   32'(m_cnt));
        done = 4'd2;
        step();
        done = 4'd0;
        step();
        chk("dis_hold_start", 32'(stage_start), 32'd0);
        chk("dis_hold_cnt",   32'(phase_cnt),   32'(m_cnt));
        chk("dis_hold_phase", 32'(phase),       32'(m_phase));
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        step();
        rst_n = 1'b1;
        step();
        chk_zero("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
